// File: rtl/mig_ui_responder_if.sv
// rtl/mig_ui_responder_if.sv - MIG 7-series app_* user interface bundle
// master = DDR2 initiator side, slave = memory controller (responder) side.
interface mig_ui_responder_if;
    logic [26:0]  app_addr;
    logic [2:0]   app_cmd;
    logic         app_en;
    logic         app_rdy;
    logic [127:0] app_wdf_data;
    logic [15:0]  app_wdf_mask;
    logic         app_wdf_wren;
    logic         app_wdf_end;
    logic         app_wdf_rdy;
    logic [127:0] app_rd_data;
    logic         app_rd_data_valid;
    logic         app_rd_data_end;
    logic         ui_clk_sync_rst;
    logic         init_calib_complete;

    modport master (
        output app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        input  app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
        input  ui_clk_sync_rst, init_calib_complete
    );

    modport slave (
        input  app_addr, app_cmd, app_en, app_wdf_data, app_wdf_mask, app_wdf_wren, app_wdf_end,
        output app_rdy, app_wdf_rdy, app_rd_data, app_rd_data_valid, app_rd_data_end,
        output ui_clk_sync_rst, init_calib_complete
    );
endinterface

// File: rtl/mig_ui_responder.sv
// rtl/mig_ui_responder.sv - BRAM-backed stand-in for the MIG 7-series app_* user interface
// Write data FIFO pairs with write commands in order; reads return after a fixed latency.
module mig_ui_responder #(
    parameter int AW           = 7,
    parameter int RD_LATENCY   = 4,
    parameter int WDF_DEPTH    = 4,
    parameter int CALIB_CYCLES = 64,
    parameter int RDY_GAP      = 0
) (
    input  logic              clk,
    input  logic              rst,
    mig_ui_responder_if.slave ui
);

    localparam int WORDS    = 2 ** AW;
    localparam int CAL_TERM = (CALIB_CYCLES > 4) ? CALIB_CYCLES : 4;
    localparam int CW       = $clog2(CAL_TERM + 1);
    localparam int PW       = $clog2(WDF_DEPTH);
    localparam int NST      = RD_LATENCY - 1;

    // One counter times both the sync-reset tail and calibration; it saturates.
    logic [CW-1:0] cal_cnt;
    logic          calib;

    always_ff @(posedge clk) begin
        if (rst) begin
            cal_cnt <= '0;
        end else if (cal_cnt != CW'(CAL_TERM)) begin
            cal_cnt <= cal_cnt + CW'(1);
        end
    end

    assign calib                  = (cal_cnt >= CW'(CALIB_CYCLES));
    assign ui.init_calib_complete = calib;
    assign ui.ui_clk_sync_rst     = (cal_cnt < CW'(4));

    // Free-running stall injector; it also runs during calibration.
    logic gap_stall;

    generate
        if (RDY_GAP > 0) begin : g_gap
            localparam int GW = (RDY_GAP > 1) ? $clog2(RDY_GAP) : 1;
            logic [GW-1:0] gap_cnt;

            always_ff @(posedge clk) begin
                if (rst) begin
                    gap_cnt <= '0;
                end else if (gap_cnt == GW'(RDY_GAP - 1)) begin
                    gap_cnt <= '0;
                end else begin
                    gap_cnt <= gap_cnt + GW'(1);
                end
            end

            assign gap_stall = (gap_cnt == '0);
        end else begin : g_nogap
            assign gap_stall = 1'b0;
        end
    endgenerate

    logic [127:0] mem [WORDS];

    logic [127:0] fifo_data [WDF_DEPTH];
    logic [15:0]  fifo_mask [WDF_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   fifo_cnt;
    logic          fifo_full;
    logic          fifo_empty;

    logic          pend_wr;
    logic [AW-1:0] pend_word;

    logic [AW-1:0] cmd_word;
    logic          cmd_acc;
    logic          wr_acc;
    logic          rd_acc;
    logic          beat_acc;
    logic          fifo_push;
    logic          fifo_pop;
    logic          bypass;

    logic          commit;
    logic [AW-1:0] commit_word;
    logic [127:0]  commit_data;
    logic [15:0]   commit_mask;

    assign fifo_full  = (fifo_cnt == (PW + 1)'(WDF_DEPTH));
    assign fifo_empty = (fifo_cnt == '0);

    assign ui.app_rdy     = calib & ~pend_wr & ~gap_stall;
    assign ui.app_wdf_rdy = calib & ~fifo_full;

    assign cmd_word = ui.app_addr[AW+2:3];
    assign cmd_acc  = ui.app_en & ui.app_rdy;
    assign wr_acc   = cmd_acc & (ui.app_cmd == 3'b000);
    assign rd_acc   = cmd_acc & (ui.app_cmd == 3'b001);
    assign beat_acc = ui.app_wdf_wren & ui.app_wdf_rdy;

    // A beat skips the FIFO when a command is already waiting for it, either
    // latched in pend_wr or accepted this cycle with nothing queued ahead.
    assign fifo_pop  = wr_acc & ~fifo_empty;
    assign bypass    = beat_acc & (pend_wr | (wr_acc & fifo_empty));
    assign fifo_push = beat_acc & ~bypass;

    always_comb begin
        commit      = 1'b0;
        commit_word = cmd_word;
        commit_data = ui.app_wdf_data;
        commit_mask = ui.app_wdf_mask;
        if (fifo_pop) begin
            commit      = 1'b1;
            commit_data = fifo_data[rd_ptr];
            commit_mask = fifo_mask[rd_ptr];
        end else if (bypass) begin
            commit = 1'b1;
            if (pend_wr) begin
                commit_word = pend_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (fifo_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({fifo_push, fifo_pop})
                2'b10:   fifo_cnt <= fifo_cnt + (PW + 1)'(1);
                2'b01:   fifo_cnt <= fifo_cnt - (PW + 1)'(1);
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (fifo_push) begin
            fifo_data[wr_ptr] <= ui.app_wdf_data;
            fifo_mask[wr_ptr] <= ui.app_wdf_mask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_wr <= 1'b0;
        end else if (pend_wr && beat_acc) begin
            pend_wr <= 1'b0;
        end else if (wr_acc && fifo_empty && !beat_acc) begin
            pend_wr   <= 1'b1;
            pend_word <= cmd_word;
        end
    end

    // Contents survive reset; only the commit itself is blocked while rst is high.
    always_ff @(posedge clk) begin
        if (commit && !rst) begin
            for (int i = 0; i < 16; i++) begin
                if (!commit_mask[i]) begin
                    mem[commit_word][8*i +: 8] <= commit_data[8*i +: 8];
                end
            end
        end
    end

    // Read data is captured at accept, so a same-cycle commit is not seen.
    logic [NST-1:0] pipe_vld;
    logic [127:0]   pipe_data [NST];
    logic [127:0]   rd_data_q;
    logic           rd_valid_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_vld <= '0;
        end else begin
            pipe_vld[0] <= rd_acc;
            for (int i = 1; i < NST; i++) begin
                pipe_vld[i] <= pipe_vld[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        pipe_data[0] <= mem[cmd_word];
        for (int i = 1; i < NST; i++) begin
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data_q  <= '0;
            rd_valid_q <= 1'b0;
        end else begin
            rd_valid_q <= pipe_vld[NST-1];
            if (pipe_vld[NST-1]) begin
                rd_data_q <= pipe_data[NST-1];
            end
        end
    end

    assign ui.app_rd_data       = rd_data_q;
    assign ui.app_rd_data_valid = rd_valid_q;
    assign ui.app_rd_data_end   = rd_valid_q;

    logic unused_ui_bits;
    assign unused_ui_bits = ^{ui.app_addr[26:AW+3], ui.app_addr[2:0], ui.app_wdf_end};

endmodule
